// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared sizes, entry payload type and drain FSM states for
// the posted-write store buffer.
package store_buffer_pkg;

    localparam int unsigned STORE_BUF_DEPTH      = 4;
    localparam int unsigned STORE_BUF_ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH           = 32;
    localparam int unsigned MASK_WIDTH           = 4;

    // Data and byte-lane mask of one buffered store
    typedef struct packed {
        logic [DATA_WIDTH-1:0] wdata;
        logic [MASK_WIDTH-1:0] wmask;
    } st_payload_t;

    localparam int unsigned PAYLOAD_WIDTH = DATA_WIDTH + MASK_WIDTH;

    // Bits held per entry: word address plus payload
    function automatic int unsigned entry_width(input int unsigned addr_width);
        return addr_width - 2 + PAYLOAD_WIDTH;
    endfunction

    localparam int unsigned STORE_BUF_ENTRY_WIDTH = entry_width(STORE_BUF_ADDR_WIDTH);

    typedef enum logic {
        DRAIN_IDLE = 1'b0,
        DRAIN_BUSY = 1'b1
    } drain_state_e;

endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if: memory-bus write channel (valid/ready handshake).
//   valid  master->slave  write request
//   ready  slave->master  write accepted
//   addr   master->slave  word-aligned byte address
//   wdata  master->slave  write data
//   wstrb  master->slave  byte strobes
interface store_buffer_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    import store_buffer_pkg::*;

    logic                  valid;
    logic                  ready;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [MASK_WIDTH-1:0] wstrb;

    modport master (
        output valid,
        output addr,
        output wdata,
        output wstrb,
        input  ready
    );

    modport slave (
        input  valid,
        input  addr,
        input  wdata,
        input  wstrb,
        output ready
    );

endinterface

// File: rtl/store_buffer_fifo.sv
// store_buffer_fifo: circular storage for pending stores.
//   clk, resetn          clock, async active-low reset
//   push                 enqueue {push_waddr, push_payload} at wr_ptr
//   pop                  drop the head entry
//   head_* / next_*      entry at rd_ptr and at rd_ptr+1
//   waddr_array, held    every slot's word address and occupancy (hazard compare)
//   count                number of occupied slots
module store_buffer_fifo
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH       = STORE_BUF_DEPTH,
    parameter int unsigned WADDR_WIDTH = STORE_BUF_ADDR_WIDTH - 2
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WADDR_WIDTH-1:0] push_waddr,
    input  st_payload_t            push_payload,
    output logic [WADDR_WIDTH-1:0] head_waddr,
    output st_payload_t            head_payload,
    output logic [WADDR_WIDTH-1:0] next_waddr,
    output st_payload_t            next_payload,
    output logic [WADDR_WIDTH-1:0] waddr_array [DEPTH],
    output logic [DEPTH-1:0]       held,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next;
    st_payload_t      payload_q [DEPTH];

    assign rd_next = rd_ptr + PTR_W'(1);

    // Pointers, occupancy and count; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            held   <= '0;
        end else begin
            if (push) begin
                wr_ptr       <= wr_ptr + PTR_W'(1);
                held[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr       <= rd_next;
                held[rd_ptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only meaningful where held is set
    always_ff @(posedge clk) begin
        if (push) begin
            waddr_array[wr_ptr] <= push_waddr;
            payload_q[wr_ptr]   <= push_payload;
        end
    end

    assign head_waddr   = waddr_array[rd_ptr];
    assign head_payload = payload_q[rd_ptr];
    assign next_waddr   = waddr_array[rd_next];
    assign next_payload = payload_q[rd_next];

endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write buffer between the core store path and the memory bus.
//   clk, resetn            clock, async active-low reset
//   st_valid/st_ready      store handshake; st_addr, st_wdata, st_wmask payload
//   ld_check, ld_addr      load probe; ld_hazard flags a pending store to that word
//   empty, count           occupancy, including the write currently on the bus
//   mem                    bus write channel (master side)
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH      = STORE_BUF_DEPTH,
    parameter int unsigned ADDR_WIDTH = STORE_BUF_ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   st_valid,
    output logic                   st_ready,
    input  logic [ADDR_WIDTH-1:0]  st_addr,
    input  logic [DATA_WIDTH-1:0]  st_wdata,
    input  logic [MASK_WIDTH-1:0]  st_wmask,
    input  logic                   ld_check,
    input  logic [ADDR_WIDTH-1:0]  ld_addr,
    output logic                   ld_hazard,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    store_buffer_if.master         mem
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned WA_W  = ADDR_WIDTH - 2;

    logic              push;
    logic              pop;
    logic              load_head;
    logic              load_next;
    logic              hit;
    logic              unused_addr_bits;
    drain_state_e      state_q;
    drain_state_e      state_d;

    logic [WA_W-1:0]   head_waddr;
    logic [WA_W-1:0]   next_waddr;
    st_payload_t       head_payload;
    st_payload_t       next_payload;
    st_payload_t       push_payload;
    logic [WA_W-1:0]   waddr_array [DEPTH];
    logic [DEPTH-1:0]  held;

    logic                  mem_valid_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic [MASK_WIDTH-1:0] mem_wstrb_q;

    // Byte offset only selects lanes, which the mask already encodes
    assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

    // Zero-mask stores complete the handshake but are never enqueued
    assign st_ready = (count < CNT_W'(DEPTH));
    assign push     = st_valid && st_ready && (st_wmask != '0);
    assign empty    = (count == '0);

    assign push_payload.wdata = st_wdata;
    assign push_payload.wmask = st_wmask;

    store_buffer_fifo #(
        .DEPTH       (DEPTH),
        .WADDR_WIDTH (WA_W)
    ) u_fifo (
        .clk          (clk),
        .resetn       (resetn),
        .push         (push),
        .pop          (pop),
        .push_waddr   (st_addr[ADDR_WIDTH-1:2]),
        .push_payload (push_payload),
        .head_waddr   (head_waddr),
        .head_payload (head_payload),
        .next_waddr   (next_waddr),
        .next_payload (next_payload),
        .waddr_array  (waddr_array),
        .held         (held),
        .count        (count)
    );

    // Drain FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= DRAIN_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Drain FSM next state; the bus entry stays counted until accepted
    always_comb begin
        state_d   = state_q;
        load_head = 1'b0;
        load_next = 1'b0;
        pop       = 1'b0;
        case (state_q)
            DRAIN_IDLE: begin
                if (count != '0) begin
                    load_head = 1'b1;
                    state_d   = DRAIN_BUSY;
                end
            end
            DRAIN_BUSY: begin
                if (mem.ready) begin
                    pop = 1'b1;
                    // Only entries already stored can follow back-to-back
                    if (count > CNT_W'(1)) begin
                        load_next = 1'b1;
                    end else begin
                        state_d = DRAIN_IDLE;
                    end
                end
            end
            default: state_d = DRAIN_IDLE;
        endcase
    end

    // Bus request registers, held stable while waiting for ready
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else if (load_head) begin
            mem_valid_q <= 1'b1;
            mem_addr_q  <= {head_waddr, 2'b00};
            mem_wdata_q <= head_payload.wdata;
            mem_wstrb_q <= head_payload.wmask;
        end else if (load_next) begin
            mem_valid_q <= 1'b1;
            mem_addr_q  <= {next_waddr, 2'b00};
            mem_wdata_q <= next_payload.wdata;
            mem_wstrb_q <= next_payload.wmask;
        end else if (pop) begin
            mem_valid_q <= 1'b0;
        end
    end

    assign mem.valid = mem_valid_q;
    assign mem.addr  = mem_addr_q;
    assign mem.wdata = mem_wdata_q;
    assign mem.wstrb = mem_wstrb_q;

    // Load hazard against every held entry, including the one on the bus
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (held[i] && (waddr_array[i] == ld_addr[ADDR_WIDTH-1:2])) begin
                hit = 1'b1;
            end
        end
    end

    assign ld_hazard = ld_check && hit;

endmodule
